// File: rtl/conv_dnn_bridge.sv
// conv_dnn_bridge: buffered glue between the last conv/pool stage and the DNN.
// Holds data after each image set until the DNN has been flushed.
module conv_dnn_bridge #(
    parameter int BitSize      = 32,
    parameter int NumIn        = 2,
    parameter int NumOfImages  = 4,
    parameter bit ReverseValid = 1'b1,
    parameter int FifoDepth    = 8,
    parameter int FlushGap     = 6,
    parameter int GuardCycles  = 2
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic [NumOfImages-1:0]   in_valid,
    input  logic [NumIn*BitSize-1:0] in_data,
    input  logic                     in_set_done,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic [NumOfImages-1:0]   out_valid,
    output logic [NumIn*BitSize-1:0] out_data,
    output logic                     out_set_done,
    output logic                     out_fl_res,
    output logic                     overflow
);
    localparam int DW        = NumIn * BitSize;
    localparam int AW        = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int WaitLast  = NumOfImages + FlushGap - 1;
    localparam int GuardLast = (GuardCycles > 0) ? GuardCycles - 1 : 0;
    localparam int CntMax    = (WaitLast > GuardLast) ? WaitLast : GuardLast;
    localparam int CW        = $clog2(CntMax + 2);

    typedef struct packed {
        logic [NumOfImages-1:0] valid;
        logic [DW-1:0]          data;
        logic                   done;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, PULSE, GUARD} state_t;

    entry_t                 mem [FifoDepth];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [AW:0]            count;
    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nx;
    logic                   qual;
    logic                   push;
    logic                   pop;
    entry_t                 head;
    logic [NumOfImages-1:0] head_valid;

    assign in_ready = (count < (AW+1)'(FifoDepth));
    assign qual     = (|in_valid) | in_set_done;
    assign push     = qual & in_ready;
    assign pop      = (state == IDLE) & (count != '0) & out_ready;
    assign head     = mem[rd_ptr];

    always_comb begin
        head_valid = head.valid;
        if (ReverseValid) begin
            for (int i = 0; i < NumOfImages; i++) begin
                head_valid[i] = head.valid[NumOfImages-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{valid: in_valid, data: in_data, done: in_set_done};
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    // Flush sequencer: pops are blocked everywhere except IDLE
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (pop && head.done) begin
                    state_nx = WAIT;
                    cnt_nx   = '0;
                end
            end
            WAIT: begin
                if (cnt == CW'(WaitLast)) begin
                    state_nx = PULSE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            PULSE: begin
                cnt_nx = '0;
                if (GuardCycles > 0) begin
                    state_nx = GUARD;
                end else begin
                    state_nx = IDLE;
                end
            end
            GUARD: begin
                if (cnt == CW'(GuardLast)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state        <= IDLE;
            cnt          <= '0;
            out_valid    <= '0;
            out_data     <= '0;
            out_set_done <= 1'b0;
            out_fl_res   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            out_valid    <= pop ? head_valid : '0;
            out_set_done <= pop & head.done;
            out_fl_res   <= (state == PULSE);
            if (pop) begin
                out_data <= head.data;
            end
            if (qual && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_dnn_bridge.sv
// tb_conv_dnn_bridge: vector table, directed corner sequences and random
// traffic against a queue/timeline reference model.
module tb_conv_dnn_bridge;
    localparam int BitSize     = 32;
    localparam int NumIn       = 2;
    localparam int NumOfImages = 4;
    localparam int FifoDepth   = 8;
    localparam int FlushGap    = 6;
    localparam int GuardCycles = 2;
    localparam int DW          = BitSize * NumIn;
    localparam int NW          = NumOfImages;
    localparam int N           = NumOfImages + FlushGap;

    logic          clk = 1'b0;
    logic          res;
    logic [NW-1:0] in_valid;
    logic [DW-1:0] in_data;
    logic          in_set_done;
    logic          out_ready;
    logic          in_ready,     r_in_ready;
    logic [NW-1:0] out_valid,    r_out_valid;
    logic [DW-1:0] out_data,     r_out_data;
    logic          out_set_done, r_out_set_done;
    logic          out_fl_res,   r_out_fl_res;
    logic          overflow,     r_overflow;

    conv_dnn_bridge #(
        .BitSize(BitSize), .NumIn(NumIn), .NumOfImages(NumOfImages),
        .ReverseValid(1'b1), .FifoDepth(FifoDepth), .FlushGap(FlushGap),
        .GuardCycles(GuardCycles)
    ) dut (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_set_done(out_set_done),
        .out_fl_res(out_fl_res), .overflow(overflow)
    );

    conv_dnn_bridge #(
        .BitSize(BitSize), .NumIn(NumIn), .NumOfImages(NumOfImages),
        .ReverseValid(1'b0), .FifoDepth(FifoDepth), .FlushGap(FlushGap),
        .GuardCycles(GuardCycles)
    ) dut_raw (
        .clk(clk), .res(res), .in_valid(in_valid), .in_data(in_data),
        .in_set_done(in_set_done), .in_ready(r_in_ready), .out_ready(out_ready),
        .out_valid(r_out_valid), .out_data(r_out_data),
        .out_set_done(r_out_set_done), .out_fl_res(r_out_fl_res),
        .overflow(r_overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [NW-1:0] v;
        logic [DW-1:0] d;
        logic          done;
    } ent_t;

    ent_t          q[$];
    int            edge_n   = 0;
    int            pop_ok   = 0;
    int            pulse_at = -1;
    logic [NW-1:0] m_v      = '0;
    logic [NW-1:0] m_vraw   = '0;
    logic [DW-1:0] m_d      = '0;
    logic          m_sd     = 1'b0;
    logic          m_fl     = 1'b0;
    logic          m_ovf    = 1'b0;

    int            out_count, sd_edge, sd_beat, fl_edge, fl_count, post_edge;
    logic [NW-1:0] sd_valid;
    logic [DW-1:0] last_data;

    typedef struct {
        logic [NW-1:0] iv;
        logic [DW-1:0] id;
        logic          isd;
        logic          ordy;
        logic [NW-1:0] ev;
        logic [DW-1:0] ed;
        logic          esd;
        logic          eir;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [NW-1:0] rev(input logic [NW-1:0] x);
        logic [NW-1:0] r;
        for (int i = 0; i < NW; i++) r[i] = x[NW-1-i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d)",
                      nm, act, exp, edge_n);
    endtask

    // Timeline model: a done pop schedules the pulse and the next pop slot
    task automatic model_step();
        ent_t e;
        bit   qual, rdy, pop;
        edge_n++;
        if (res) begin
            q.delete();
            pop_ok = 0; pulse_at = -1;
            m_v = '0; m_vraw = '0; m_d = '0;
            m_sd = 1'b0; m_fl = 1'b0; m_ovf = 1'b0;
            return;
        end
        rdy  = q.size() < FifoDepth;
        qual = (|in_valid) || in_set_done;
        pop  = (edge_n >= pop_ok) && (q.size() > 0) && out_ready;
        m_v = '0; m_vraw = '0; m_sd = 1'b0;
        if (pop) begin
            e = q.pop_front();
            m_vraw = e.v;
            m_v    = rev(e.v);
            m_d    = e.d;
            m_sd   = e.done;
            if (e.done) begin
                pulse_at = edge_n + N + 1;
                pop_ok   = edge_n + N + GuardCycles + 2;
            end
        end
        m_fl = (edge_n == pulse_at);
        if (qual && rdy) q.push_back('{in_valid, in_data, in_set_done});
        else if (qual) m_ovf = 1'b1;
    endtask

    task automatic compare();
        chk("out_valid", out_valid, m_v);
        chk("out_data", out_data, m_d);
        chk("out_set_done", out_set_done, m_sd);
        chk("out_fl_res", out_fl_res, m_fl);
        chk("overflow", overflow, m_ovf);
        chk("in_ready", in_ready, q.size() < FifoDepth);
        chk("raw_out_valid", r_out_valid, m_vraw);
        chk("raw_out_data", r_out_data, m_d);
        chk("raw_out_fl_res", r_out_fl_res, m_fl);
        chk("raw_out_set_done", r_out_set_done, m_sd);
    endtask

    task automatic track();
        if (out_valid != '0 || out_set_done) begin
            out_count++;
            last_data = out_data;
            if (out_set_done) begin
                sd_edge  = edge_n;
                sd_beat  = out_count;
                sd_valid = out_valid;
            end
            if (fl_edge >= 0 && post_edge < 0 && edge_n > fl_edge)
                post_edge = edge_n;
        end
        if (out_fl_res) begin
            fl_count++;
            fl_edge = edge_n;
        end
    endtask

    task automatic clr_trk();
        out_count = 0; sd_edge = -1; sd_beat = -1; fl_edge = -1;
        fl_count = 0; post_edge = -1; sd_valid = '1; last_data = '0;
    endtask

    task automatic drive(input logic r, input logic [NW-1:0] v,
                         input logic [DW-1:0] d, input logic sd,
                         input logic ordy);
        res = r; in_valid = v; in_data = d; in_set_done = sd; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        track();
    endtask

    task automatic reset_dut();
        drive(1'b1, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        tbl[0] = '{4'b0001, {32'h22, 32'h11}, 1'b0, 1'b1, 4'b0000, 64'h0, 1'b0, 1'b1};
        tbl[1] = '{4'b0000, 64'h0, 1'b0, 1'b1, 4'b1000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[2] = '{4'b0000, 64'h0, 1'b0, 1'b1, 4'b0000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 64'hBBBB, 1'b0, 1'b1, 4'b0000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 64'h0, 1'b0, 1'b1, 4'b0000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[5] = '{4'b0011, 64'hC0FFEE, 1'b0, 1'b0, 4'b0000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[6] = '{4'b0000, 64'h0, 1'b0, 1'b0, 4'b0000, {32'h22, 32'h11}, 1'b0, 1'b1};
        tbl[7] = '{4'b0000, 64'h0, 1'b0, 1'b1, 4'b1100, 64'hC0FFEE, 1'b0, 1'b1};
        tbl[8] = '{4'b0000, 64'h0, 1'b0, 1'b1, 4'b0000, 64'hC0FFEE, 1'b0, 1'b1};
        clr_trk();

        // reset held with random inputs, then quiet release
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, NW'($urandom), {$urandom, $urandom},
                  1'($urandom), 1'($urandom));
            tick();
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_overflow", overflow, 0);
            chk("rst_fl_res", out_fl_res, 0);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_out_valid", out_valid, 0);
            chk("idle_set_done", out_set_done, 0);
        end

        // passthrough vector table
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, tbl[i].iv, tbl[i].id, tbl[i].isd, tbl[i].ordy);
            tick();
            chk("tbl_out_valid", out_valid, tbl[i].ev);
            chk("tbl_out_data", out_data, tbl[i].ed);
            chk("tbl_set_done", out_set_done, tbl[i].esd);
            chk("tbl_in_ready", in_ready, tbl[i].eir);
            chk("tbl_raw_valid", r_out_valid, rev(tbl[i].ev));
        end

        // flush: four beats, fifth pushed while waiting
        reset_dut();
        clr_trk();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'b1111, {32'(i), 32'hA0 + 32'(i)}, i == 3, 1'b1);
            tick();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        drive(1'b0, 4'b0101, 64'h5555, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (25) tick();
        chk("flush_sd_beat", sd_beat, 4);
        chk("flush_pulse_gap", fl_edge - sd_edge, N + 1);
        chk("flush_pulse_width", fl_count, 1);
        chk("flush_guard_gap", post_edge - fl_edge, GuardCycles + 1);
        chk("flush_fifth_data", last_data, 64'h5555);

        // backpressure: nine beats into a stalled FIFO
        reset_dut();
        clr_trk();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 4'b1000, {32'hB0 + 32'(i), 32'(i)}, 1'b0, 1'b0);
            tick();
            if (i == 6) chk("bp_ready_high", in_ready, 1);
            if (i == 7) chk("bp_ready_low", in_ready, 0);
        end
        chk("bp_overflow", overflow, 1);
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (14) tick();
        chk("bp_drain_count", out_count, 8);
        chk("bp_last_data", last_data, {32'hB7, 32'h7});
        chk("bp_overflow_sticky", overflow, 1);

        // simultaneous push and pop with three entries held
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'b0100, {32'hC0 + 32'(i), 32'(i)}, 1'b0, 1'b0);
            tick();
        end
        clr_trk();
        for (int i = 3; i < 13; i++) begin
            drive(1'b0, 4'b0100, {32'hC0 + 32'(i), 32'(i)}, 1'b0, 1'b1);
            tick();
            chk("sim_in_ready", in_ready, 1);
        end
        chk("sim_out_count", out_count, 10);
        chk("sim_no_overflow", overflow, 0);
        clr_trk();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (8) tick();
        chk("sim_drain_count", out_count, 3);
        chk("sim_drain_last", last_data, {32'hCC, 32'd12});

        // reset while waiting, then a set ending in a valid-less done beat
        reset_dut();
        drive(1'b0, 4'b0001, 64'h77, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (4) tick();
        clr_trk();
        drive(1'b1, '0, '0, 1'b0, 1'b1);
        tick();
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (20) tick();
        chk("abort_no_pulse", fl_count, 0);
        clr_trk();
        drive(1'b0, 4'b0010, 64'h88, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'b0000, 64'h99, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, '0, 1'b0, 1'b1);
        repeat (20) tick();
        chk("abort_new_gap", fl_edge - sd_edge, N + 1);
        chk("abort_done_beat", sd_beat, 2);
        chk("done_novalid_valid", sd_valid, 0);

        // random traffic against the model
        for (int k = 0; k < 800; k++) begin
            drive($urandom_range(0, 99) == 0,
                  ($urandom_range(0, 1) != 0) ? NW'($urandom) : NW'(0),
                  {$urandom, $urandom},
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
